// File: rtl/bk_sd_xfer.sv
// Backup-RAM sector transfer engine: streams the backup SRAM image to/from the
// HPS virtual-disk port one 512-byte sector at a time.
module bk_sd_xfer #(
    parameter int NUM_SECTORS = 64,
    parameter int SEC_W       = $clog2(NUM_SECTORS)
) (
    input  logic                clk_sys,
    input  logic                reset_n,

    input  logic                img_mounted,
    input  logic                img_readonly,
    input  logic [63:0]         img_size,

    input  logic                bk_load,
    input  logic                bk_save,
    output logic                bk_ena,
    output logic                bk_loading,
    output logic                bk_saving,

    output logic [31:0]         sd_lba,
    output logic                sd_rd,
    output logic                sd_wr,
    input  logic                sd_ack,
    input  logic [7:0]          sd_buff_addr,
    input  logic [15:0]         sd_buff_dout,
    input  logic                sd_buff_wr,
    output logic [15:0]         sd_buff_din,

    output logic [SEC_W+7:0]    ram_addr,
    output logic                ram_we,
    output logic [15:0]         ram_din,
    input  logic [15:0]         ram_dout
);

    // state | meaning
    // IDLE  | no transfer; waiting for a load/save request edge
    // REQ   | sd_rd/sd_wr raised for the current sector; waiting for sd_ack
    // XFER  | host is moving the sector; waiting for sd_ack to drop
    // NEXT  | sector finished; advance to the next one or return to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        NEXT = 2'd3
    } state_t;

    localparam logic [63:0]      IMG_BYTES = 64'(NUM_SECTORS) * 64'd512;
    localparam logic [SEC_W-1:0] LAST_SEC  = SEC_W'(NUM_SECTORS - 1);

    state_t           state;
    state_t           state_nx;
    logic [SEC_W-1:0] sector;
    logic             dir;
    logic             dir_nx;
    logic             ro;
    logic             bk_load_q;
    logic             bk_save_q;
    logic             load_edge;
    logic             save_edge;
    logic             start_load;
    logic             start_save;
    logic             busy;

    assign load_edge  = bk_load & ~bk_load_q;
    assign save_edge  = bk_save & ~bk_save_q;
    // A load wins when both edges land in the same cycle.
    assign start_load = load_edge & bk_ena;
    assign start_save = save_edge & bk_ena & ~ro & ~start_load;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_load || start_save) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (sd_ack) begin
                    state_nx = XFER;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    state_nx = NEXT;
                end
            end
            NEXT: begin
                state_nx = (sector == LAST_SEC) ? IDLE : REQ;
            end
            default: state_nx = IDLE;
        endcase
        // A remount invalidates whatever image was being transferred.
        if (img_mounted && state != IDLE) begin
            state_nx = IDLE;
        end
    end

    assign dir_nx = (state == IDLE) ? start_save : dir;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sector    <= '0;
            dir       <= 1'b0;
            bk_ena    <= 1'b0;
            ro        <= 1'b0;
            bk_load_q <= 1'b0;
            bk_save_q <= 1'b0;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
        end else begin
            bk_load_q <= bk_load;
            bk_save_q <= bk_save;
            if (img_mounted) begin
                bk_ena <= (img_size >= IMG_BYTES);
                ro     <= img_readonly;
            end
            if (state == IDLE && state_nx == REQ) begin
                sector <= '0;
                dir    <= start_save;
            end else if (state == NEXT && state_nx == REQ) begin
                sector <= sector + 1'b1;
            end
            // Registered so the request is clean and drops the cycle after ack.
            sd_rd <= (state_nx == REQ) & ~dir_nx;
            sd_wr <= (state_nx == REQ) & dir_nx;
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        bk_loading  = busy & ~dir;
        bk_saving   = busy & dir;
        sd_lba      = busy ? 32'(sector) : 32'd0;
        ram_addr    = {sector, sd_buff_addr};
        ram_din     = sd_buff_dout;
        ram_we      = sd_buff_wr & sd_ack & bk_loading;
        sd_buff_din = ram_dout;
    end

endmodule

// File: tb/tb_bk_sd_xfer.sv
// Scoreboard bench for bk_sd_xfer: a host model serves sector requests while an
// SRAM model backs the RAM port; expected LBAs, writes and read data are queued.
module tb_bk_sd_xfer;

    localparam int NS    = 64;
    localparam int SEC_W = 6;

    logic              clk_sys;
    logic              reset_n;
    logic              img_mounted;
    logic              img_readonly;
    logic [63:0]       img_size;
    logic              bk_load;
    logic              bk_save;
    logic              bk_ena;
    logic              bk_loading;
    logic              bk_saving;
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack;
    logic [7:0]        sd_buff_addr;
    logic [15:0]       sd_buff_dout;
    logic              sd_buff_wr;
    logic [15:0]       sd_buff_din;
    logic [SEC_W+7:0]  ram_addr;
    logic              ram_we;
    logic [15:0]       ram_din;
    logic [15:0]       ram_dout;

    bk_sd_xfer #(.NUM_SECTORS(NS)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size     (img_size),
        .bk_load      (bk_load),
        .bk_save      (bk_save),
        .bk_ena       (bk_ena),
        .bk_loading   (bk_loading),
        .bk_saving    (bk_saving),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_we   = 0;
    int          lba_q[$];
    logic [31:0] wr_q[$];
    logic [15:0] din_q[$];
    logic [15:0] mem [0:16383];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Image content: each word is its word address XOR 0xA5A5.
    function automatic logic [15:0] fword(input int a);
        return 16'(a) ^ 16'hA5A5;
    endfunction

    function automatic logic [7:0] file_byte(input int b);
        logic [15:0] w;
        w = fword(b >> 1);
        return b[0] ? w[15:8] : w[7:0];
    endfunction

    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    always @(negedge clk_sys) begin
        if (ram_we) begin
            logic [31:0] e;
            n_we++;
            if (wr_q.size() == 0) begin
                check_val("ram_we_spurious", 1, 0);
            end else begin
                e = wr_q.pop_front();
                check_val("ram_addr", ram_addr, e[29:16]);
                check_val("ram_din", ram_din, e[15:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic mount(input logic [63:0] sz, input logic rdonly, input logic exp_ena);
        tick();
        img_mounted  = 1'b1;
        img_size     = sz;
        img_readonly = rdonly;
        tick();
        img_mounted  = 1'b0;
        @(negedge clk_sys);
        check_val("bk_ena", bk_ena, exp_ena);
    endtask

    task automatic pulse_req(input logic ld, input logic sv);
        tick();
        bk_load = ld;
        bk_save = sv;
        @(negedge clk_sys);
        @(negedge clk_sys);
        tick();
        bk_load = 1'b0;
        bk_save = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic push_lbas();
        for (int s = 0; s < NS; s++) lba_q.push_back(s);
    endtask

    task automatic host_sector(input logic save, input int nw);
        int i;
        int sec;
        i = 0;
        while (!(sd_rd || sd_wr) && i < 100) begin
            @(negedge clk_sys);
            i++;
        end
        if (i >= 100) begin
            check_val("req_wait", 0, 1);
            return;
        end
        if (lba_q.size() == 0) begin
            check_val("lba_extra", 1, 0);
            return;
        end
        sec = lba_q.pop_front();
        check_val("sd_lba", sd_lba, sec);
        check_val("sd_rd", sd_rd, !save);
        check_val("sd_wr", sd_wr, save);
        tick();
        sd_ack = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        check_val("req_drop", {sd_rd, sd_wr}, 0);
        if (!save) begin
            for (int w = 0; w < nw; w++) begin
                tick();
                sd_buff_addr = 8'(w);
                sd_buff_dout = fword(sec * 256 + w);
                sd_buff_wr   = 1'b1;
                wr_q.push_back({2'b00, 14'(sec * 256 + w), fword(sec * 256 + w)});
            end
            tick();
            sd_buff_wr = 1'b0;
        end else begin
            for (int w = 0; w <= nw; w++) begin
                tick();
                if (w < nw) begin
                    sd_buff_addr = 8'(w);
                    din_q.push_back(fword(sec * 256 + w));
                end
                @(negedge clk_sys);
                if (w > 0) check_val("sd_buff_din", sd_buff_din, din_q.pop_front());
            end
        end
        tick();
        sd_ack       = 1'b0;
        sd_buff_addr = 8'd0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        check_val("next_busy", save ? bk_saving : bk_loading, 1);
        check_val("next_quiet", {sd_rd, sd_wr}, 0);
        @(negedge clk_sys);
        if (sec == NS - 1) check_val("done_idle", {bk_loading, bk_saving}, 0);
        else               check_val("next_req", save ? sd_wr : sd_rd, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int we0;
        logic hold;
        reset_n      = 1'b0;
        img_mounted  = 1'b0;
        img_readonly = 1'b0;
        img_size     = 64'd0;
        bk_load      = 1'b0;
        bk_save      = 1'b0;
        sd_ack       = 1'b0;
        sd_buff_addr = 8'd0;
        sd_buff_dout = 16'd0;
        sd_buff_wr   = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_val("rst_outs", {bk_ena, bk_loading, bk_saving, sd_rd, sd_wr, ram_we}, 0);
        check_val("rst_lba", sd_lba, 0);
        tick();
        reset_n = 1'b1;

        // Undersized image: requests ignored.
        mount(64'd16384, 1'b0, 1'b0);
        pulse_req(1'b1, 1'b1);
        check_val("small_busy", {bk_loading, bk_saving, sd_rd, sd_wr}, 0);

        // Full load.
        mount(64'd32768, 1'b0, 1'b1);
        push_lbas();
        we0 = n_we;
        pulse_req(1'b1, 1'b0);
        check_val("load_start", {bk_loading, bk_saving, sd_rd, sd_wr}, 4'b1010);
        for (int s = 0; s < NS; s++) host_sector(1'b0, 256);
        check_val("load_we_count", n_we - we0, 16384);
        check_val("load_word_1234", mem[14'h1234], {file_byte(32'h2469), file_byte(32'h2468)});

        // Full save of what was just loaded.
        push_lbas();
        pulse_req(1'b0, 1'b1);
        check_val("save_start", {bk_loading, bk_saving, sd_rd, sd_wr}, 4'b0101);
        for (int s = 0; s < NS; s++) host_sector(1'b1, 256);

        // Read-only image: save refused, load still works.
        mount(64'd32768, 1'b1, 1'b1);
        pulse_req(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk_sys);
            check_val("ro_no_wr", sd_wr, 0);
            check_val("ro_no_saving", bk_saving, 0);
        end
        push_lbas();
        pulse_req(1'b1, 1'b0);
        check_val("ro_load_start", bk_loading, 1);
        for (int s = 0; s < NS; s++) host_sector(1'b0, 4);

        // Simultaneous edges: load wins; then stall the ack.
        mount(64'd32768, 1'b0, 1'b1);
        push_lbas();
        pulse_req(1'b1, 1'b1);
        check_val("both_start", {bk_loading, bk_saving, sd_rd, sd_wr}, 4'b1010);
        hold = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            @(negedge clk_sys);
            hold &= sd_rd & bk_loading & ~sd_wr;
        end
        check_val("ack_hold", hold, 1);
        check_val("ack_hold_lba", sd_lba, 0);
        for (int s = 0; s < NS; s++) host_sector(1'b0, 4);

        // Remount during a transfer aborts it.
        push_lbas();
        pulse_req(1'b1, 1'b0);
        for (int s = 0; s < 2; s++) host_sector(1'b0, 4);
        tick();
        img_mounted = 1'b1;
        img_size    = 64'd32768;
        tick();
        img_mounted = 1'b0;
        @(negedge clk_sys);
        check_val("abort_idle", {bk_loading, sd_rd, bk_ena}, 3'b001);
        lba_q.delete();

        // Reset during sector 10, then restart from LBA 0.
        push_lbas();
        pulse_req(1'b1, 1'b0);
        for (int s = 0; s < 10; s++) host_sector(1'b0, 4);
        check_val("sec10_lba", sd_lba, 10);
        tick();
        sd_ack = 1'b1;
        tick();
        tick();
        #2;
        reset_n    = 1'b0;
        sd_buff_wr = 1'b1;
        #1;
        check_val("midrst_outs", {bk_ena, bk_loading, bk_saving, sd_rd, sd_wr, ram_we}, 0);
        check_val("midrst_lba", sd_lba, 0);
        tick();
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        reset_n    = 1'b1;
        lba_q.delete();
        mount(64'd32768, 1'b0, 1'b1);
        push_lbas();
        pulse_req(1'b1, 1'b0);
        check_val("restart_lba", sd_lba, 0);
        for (int s = 0; s < NS; s++) host_sector(1'b0, 4);

        check_val("wr_q_empty", wr_q.size(), 0);
        check_val("lba_q_empty", lba_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bk_sd_xfer.md
# bk_sd_xfer

Backup-RAM sector transfer engine inside `pcfx_top`, between the HPS virtual-disk port (`sd_*`, VD 0 "sram") and the dual-port backup SRAM's host port. On a `bk_load` or `bk_save` request it walks every 512-byte sector of the backup image. Loads write `sd_buff_dout` words into SRAM; saves stream SRAM words onto `sd_buff_din`. It drives the `bk_ena`, `bk_loading` and `bk_saving` status seen at the `pcfx_top` level.

## Interface
- `NUM_SECTORS`, 64: sectors per image (64 = 32 KiB internal backup RAM). Power of two, 2..256.
- `SEC_W`, `$clog2(NUM_SECTORS)`: sector index width.
- `clk_sys`  in  1  core clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `img_mounted`  in  1  mount strobe; sampled while high.
- `img_readonly`  in  1  image read-only flag; sampled with `img_mounted`.
- `img_size`  in  64  image size in bytes; sampled with `img_mounted`.
- `bk_load`, `bk_save`  in  1  OSD requests, level; acted on at the rising edge only.
- `bk_ena`  out  1  a valid image is mounted.
- `bk_loading`, `bk_saving`  out  1  a transfer is in progress.
- `sd_lba`  out  32  sector LBA, `{0, sector}`.
- `sd_rd`, `sd_wr`  out  1  sector read / write request.
- `sd_ack`  in  1  host acknowledge; high for the whole sector.
- `sd_buff_addr`  in  8  word index within the sector.
- `sd_buff_dout`  in  16  load data.
- `sd_buff_wr`  in  1  load data strobe.
- `sd_buff_din`  out  16  save data.
- `ram_addr`  out  SEC_W+8  SRAM word address.
- `ram_we`  out  1  SRAM write strobe.
- `ram_din`  out  16  SRAM write data.
- `ram_dout`  in  16  SRAM read data; 1-cycle registered latency from `ram_addr`.

## Operation
- Mount: each cycle `img_mounted` is high, set `bk_ena` = (`img_size` >= NUM_SECTORS*512) and latch `ro` = `img_readonly`. A mount strobe during a transfer aborts it to IDLE.
- Edge detect: `bk_load`/`bk_save` are registered. A request is `bk_x & ~bk_x_q`. Requests that arrive outside IDLE are dropped; they are not queued.
- FSM states: IDLE, REQ, XFER, NEXT.
  - IDLE -> REQ on a load edge with `bk_ena`, or a save edge with `bk_ena & ~ro`. A load takes priority if both edges occur in the same cycle.
  - On entering REQ: `sector` = 0, latch direction `dir` (0 = load, 1 = save).
  - REQ: drive `sd_rd` = ~dir, `sd_wr` = dir. Go to XFER when `sd_ack` is high.
  - XFER: `sd_rd`/`sd_wr` = 0. Go to NEXT when `sd_ack` is low.
  - NEXT: if `sector` == NUM_SECTORS-1, go to IDLE; otherwise `sector` += 1 and go to REQ.
- `bk_loading` = (state != IDLE) & ~dir. `bk_saving` = (state != IDLE) & dir.
- `sd_lba` = zero-extended `sector` whenever the block is busy; 0 in IDLE.
- `ram_addr` = {`sector`, `sd_buff_addr`}, combinational.
- `ram_din` = `sd_buff_dout`.
- `ram_we` = `sd_buff_wr & sd_ack & bk_loading`.
- `sd_buff_din` = `ram_dout`, passed straight through. It is valid 1 cycle after `sd_buff_addr` changes.
- The sector counter never wraps. A transfer is always exactly NUM_SECTORS sectors.

## Timing
- Reset values: all outputs 0. State IDLE, `sector` 0, `bk_ena` 0, `ro` 0, edge registers 0.
- The request edge at cycle N puts the block in REQ at N+1. `sd_rd`/`sd_wr` go high at N+1 (registered).
- `sd_rd`/`sd_wr` drop in the cycle after `sd_ack` is first sampled high. They are never high while in XFER.
- From `sd_ack` falling (sampled at M), the next sector's request is high at M+2.
- `bk_loading`/`bk_saving` are high from N+1 through the NEXT cycle of the last sector. They fall together with the return to IDLE.
- Save data: the host must sample `sd_buff_din` no earlier than 1 cycle after changing `sd_buff_addr`.
- Load writes are 1 per `sd_buff_wr` cycle, with no added latency.
- If `bk_ena` falls mid-transfer, the transfer continues; only a mount strobe aborts it. On abort, `sd_rd`/`sd_wr` fall in the next cycle.
- Asserting `reset_n` low mid-sector clears all outputs immediately; no partial-sector recovery.

## Test plan
- Mount a 32768-byte file, pulse `bk_load`. Expect 64 `sd_rd` requests with `sd_lba` 0..63 and 16384 `ram_we` pulses. SRAM word 0x1234 equals file bytes at 0x2468/0x2469 (little-endian). `bk_loading` falls after sector 63.
- Save with a known SRAM pattern (word = address ^ 0xA5A5). Expect 64 `sd_wr` requests and an output file that matches byte-for-byte. `sd_buff_din` = 0xA5A5 ^ {sector, addr} at each sample.
- Readonly mount, pulse `bk_save`: `sd_wr` stays 0, `bk_saving` stays 0. A following `bk_load` proceeds normally.
- Mount a 16384-byte file: `bk_ena` = 0 and both requests are ignored. Raise `bk_load` and `bk_save` in the same cycle on a valid image: a load runs, not a save.
- Hold `sd_ack` low for 50 cycles after `sd_rd`. `sd_rd` stays high and the state stays REQ.
- Pulse `reset_n` low during sector 10: all outputs 0 at once. A subsequent load restarts from LBA 0.
